contador_programa: RTL

- Program-counter / fetch-sequencing stage that sits directly upstream of the opcode decoder.
- Produces the instruction address each cycle and consumes the decoder's Desvio, TypeJR and Halt outputs plus the current opcode to choose the next PC.
- Stalls on IN until the operator confirms with a debounced push-button, and freezes permanently on HALT.
- Also counts retired instructions for the OS scheduler/debug display.

---
 rtl/contador_programa.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/contador_programa.sv
// Program counter and fetch sequencer: picks the next instruction address from the
// decoder flags, stalls on IN until a debounced button press, and freezes on HALT.
module contador_programa #(
    parameter int ADDR_W   = 10,
    parameter int DEBOUNCE = 4,
    parameter int CNT_W    = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [5:0]        Opcode,
    input  logic              Desvio,
    input  logic              TypeJR,
    input  logic              Halt,
    input  logic              Zero,
    input  logic [ADDR_W-1:0] Imediato,
    input  logic [ADDR_W-1:0] RegJR,
    input  logic              Botao,
    output logic [ADDR_W-1:0] PC,
    output logic              IoStrobe,
    output logic              Waiting,
    output logic              Halted,
    output logic [CNT_W-1:0]  InstrCount
);

    localparam logic [5:0] OP_JUMP = 6'b000101;
    localparam logic [5:0] OP_BEQ  = 6'b001010;
    localparam logic [5:0] OP_BNE  = 6'b001011;
    localparam logic [5:0] OP_HALT = 6'b011001;

    localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_WAIT_IN = 2'd1,
        S_HALTED  = 2'd2
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              sync1_q;
    logic              sync2_q;
    logic [DW-1:0]     deb_cnt_q;
    logic              deb_level_q;
    logic              deb_prev_q;
    logic              press_pulse;

    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] pc_d;

    // Button path: 2-FF synchronizer, then the level only moves after DEBOUNCE
    // consecutive disagreeing samples.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            deb_cnt_q   <= '0;
            deb_level_q <= 1'b0;
            deb_prev_q  <= 1'b0;
        end else begin
            sync1_q    <= Botao;
            sync2_q    <= sync1_q;
            deb_prev_q <= deb_level_q;
            if (sync2_q != deb_level_q) begin
                if (deb_cnt_q == DEB_LAST) begin
                    deb_level_q <= sync2_q;
                    deb_cnt_q   <= '0;
                end else begin
                    deb_cnt_q <= deb_cnt_q + DW'(1);
                end
            end else begin
                deb_cnt_q <= '0;
            end
        end
    end

    assign press_pulse = deb_level_q & ~deb_prev_q;

    // NOTE: every path assigns pc_d after its default, so no latch is inferred.
    always_comb begin
        pc_inc = pc_q + ADDR_W'(1);
        pc_d   = pc_inc;
        if (Desvio) begin
            if (TypeJR) begin
                pc_d = RegJR;
            end else begin
                case (Opcode)
                    OP_JUMP: pc_d = Imediato;
                    OP_BEQ:  pc_d = Zero ? Imediato : pc_inc;
                    OP_BNE:  pc_d = Zero ? pc_inc : Imediato;
                    default: pc_d = pc_inc;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_RUN;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (Opcode == OP_HALT) begin
                        state_q <= S_HALTED;
                    end else if (Halt) begin
                        state_q <= S_WAIT_IN;
                    end else begin
                        pc_q  <= pc_d;
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_WAIT_IN: begin
                    // The IN instruction retires on the edge where its write lands.
                    if (press_pulse) begin
                        pc_q    <= pc_inc;
                        cnt_q   <= cnt_q + CNT_W'(1);
                        state_q <= S_RUN;
                    end
                end
                S_HALTED: begin
                    state_q <= S_HALTED;
                end
                default: begin
                    state_q <= S_RUN;
                end
            endcase
        end
    end

    assign PC         = pc_q;
    assign InstrCount = cnt_q;
    assign Waiting    = (state_q == S_WAIT_IN);
    assign Halted     = (state_q == S_HALTED);
    assign IoStrobe   = (state_q == S_WAIT_IN) && press_pulse;

endmodule
